// File: rtl/flag_scheduler_if.sv
// flag_scheduler_if: frame/button/pixel inputs and flag-select outputs of the
// flag scheduler. The master side drives timing and buttons and reads the selection.
interface flag_scheduler_if #(
  parameter int SEL_W = 4
) ();
  logic             frame_start_i;
  logic             btn_next_i;
  logic             btn_prev_i;
  logic             auto_en_i;
  logic [9:0]       pix_x_i;
  logic [SEL_W-1:0] flag_sel_o;
  logic [SEL_W-1:0] pix_sel_o;
  logic             busy_o;

  modport master (
    output frame_start_i, btn_next_i, btn_prev_i, auto_en_i, pix_x_i,
    input  flag_sel_o, pix_sel_o, busy_o
  );

  modport slave (
    input  frame_start_i, btn_next_i, btn_prev_i, auto_en_i, pix_x_i,
    output flag_sel_o, pix_sel_o, busy_o
  );
endinterface

// File: rtl/flag_scheduler.sv
// flag_scheduler: picks which pride flag the colour mux shows. Auto-advances
// after a dwell time, takes debounced next/prev presses, and commits every
// change at a frame boundary so no frame tears.
// Optional macro FLAG_SCHEDULER_WIPE_EN adds a left-to-right wipe from the old
// flag to the new one, advancing WIPE_STEP pixels per frame.
//
// state | meaning
// SHOW  | flag_sel on screen; steps accepted (only state without the wipe)
// WIPE  | edge at wipe_x: target left of it, flag_sel right of it; presses dropped
module flag_scheduler #(
  parameter int NUM_FLAGS       = 16,
  parameter int SEL_W           = 4,
  parameter int DWELL_FRAMES    = 300,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int WIPE_STEP       = 16
) (
  input logic              clk_i,
  input logic              reset_i,
  flag_scheduler_if.slave  bus
);

  localparam int DB_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int DW_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_FRAMES);
  localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL_FRAMES - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_FLAGS - 1);

  logic                 fs;
  logic [1:0]           btn;           // [0]=next, [1]=prev
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]           armed_q, armed_d;
  logic [1:0]           press;
  logic [DW_W-1:0]      dwell_q, dwell_d;
  logic [SEL_W-1:0]     flag_sel_q, flag_sel_d;
  logic                 in_show;
  logic                 step_req;
  logic                 step_fwd;
  logic [SEL_W-1:0]     next_idx, prev_idx, step_idx;

  assign fs  = bus.frame_start_i;
  assign btn = {bus.btn_prev_i, bus.btn_next_i};

  // Per-button debounce: saturating frame count, one press per hold via arm flag
  always_comb begin
    db_cnt_d = db_cnt_q;
    armed_d  = armed_q;
    press    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (fs) begin
        if (!btn[i]) begin
          db_cnt_d[i] = '0;
          armed_d[i]  = 1'b1;
        end else begin
          if (db_cnt_q[i] != DB_MAX) db_cnt_d[i] = db_cnt_q[i] + 1'b1;
          if (armed_q[i] && (db_cnt_d[i] == DB_MAX)) begin
            press[i]   = 1'b1;
            armed_d[i] = 1'b0;
          end
        end
      end
    end
  end

  assign next_idx = (flag_sel_q == IDX_LAST) ? '0 : flag_sel_q + 1'b1;
  assign prev_idx = (flag_sel_q == '0) ? IDX_LAST : flag_sel_q - 1'b1;
  assign step_idx = step_fwd ? next_idx : prev_idx;

  // Request resolution: a lone manual press beats dwell expiry; both presses cancel
  always_comb begin
    step_req = 1'b0;
    step_fwd = 1'b1;
    dwell_d  = dwell_q;
    if (fs && in_show) begin
      if (press[0] ^ press[1]) begin
        step_req = 1'b1;
        step_fwd = press[0];
        dwell_d  = '0;
      end else if (!press[0] && !press[1] && bus.auto_en_i) begin
        if (dwell_q == DW_LAST) begin
          step_req = 1'b1;
          dwell_d  = '0;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
    end
  end

`ifdef FLAG_SCHEDULER_WIPE_EN
  typedef enum logic {SHOW, WIPE} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic [9:0]       wipe_x_q, wipe_x_d;
  logic             busy_q, busy_d;
  logic [10:0]      wipe_sum;

  assign in_show  = (state_q == SHOW);
  assign wipe_sum = {1'b0, wipe_x_q} + 11'(WIPE_STEP);

  // Wipe FSM: a step starts a wipe; flag_sel only commits once the edge passes 640
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    wipe_x_d   = wipe_x_q;
    busy_d     = busy_q;
    flag_sel_d = flag_sel_q;
    case (state_q)
      SHOW: begin
        if (step_req) begin
          target_d = step_idx;
          wipe_x_d = '0;
          busy_d   = 1'b1;
          state_d  = WIPE;
        end
      end
      WIPE: begin
        if (fs) begin
          if (wipe_sum >= 11'd640) begin
            flag_sel_d = target_q;
            wipe_x_d   = '0;
            busy_d     = 1'b0;
            state_d    = SHOW;
          end else begin
            wipe_x_d = wipe_sum[9:0];
          end
        end
      end
    endcase
  end

  // Wipe state registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= SHOW;
      target_q <= '0;
      wipe_x_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      wipe_x_q <= wipe_x_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.pix_sel_o = (busy_q && (bus.pix_x_i < wipe_x_q)) ? target_q : flag_sel_q;
  assign bus.busy_o    = busy_q;
`else
  logic unused_inputs;

  assign in_show       = 1'b1;
  assign flag_sel_d    = step_req ? step_idx : flag_sel_q;
  assign bus.pix_sel_o = flag_sel_q;
  assign bus.busy_o    = 1'b0;
  assign unused_inputs = ^{bus.pix_x_i, 11'(WIPE_STEP)};
`endif

  // Committed flag, dwell timer and debounce state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      flag_sel_q <= '0;
      dwell_q    <= '0;
      db_cnt_q   <= '0;
      armed_q    <= 2'b00;
    end else begin
      flag_sel_q <= flag_sel_d;
      dwell_q    <= dwell_d;
      db_cnt_q   <= db_cnt_d;
      armed_q    <= armed_d;
    end
  end

  assign bus.flag_sel_o = flag_sel_q;

endmodule

// File: tb/tb_flag_scheduler.sv
// tb_flag_scheduler: directed stimulus with a scoreboard queue. The driver
// pushes hand-computed expectations; a negedge monitor pops and compares.
// Wipe scenarios run when FLAG_SCHEDULER_WIPE_EN is defined.
module tb_flag_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  flag_scheduler_if #(.SEL_W(4)) bus ();

  flag_scheduler #(
    .NUM_FLAGS      (16),
    .SEL_W          (4),
    .DWELL_FRAMES   (4),
    .DEBOUNCE_FRAMES(3),
    .WIPE_STEP      (16)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  typedef struct {
    string      name;
    logic [3:0] flag;
    logic [3:0] pix;
    logic       busy;
  } exp_t;

  exp_t       sb[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [3:0] cur_flag = 4'd0;

  // Monitor: compare the oldest expectation against the settled outputs
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if (bus.flag_sel_o !== e.flag || bus.pix_sel_o !== e.pix || bus.busy_o !== e.busy) begin
        n_fail++;
        $display("FAIL %s: got flag_sel=%0d pix_sel=%0d busy=%0d (pix_x=%0d), expected flag_sel=%0d pix_sel=%0d busy=%0d",
                 e.name, bus.flag_sel_o, bus.pix_sel_o, bus.busy_o, bus.pix_x_i, e.flag, e.pix, e.busy);
      end
    end
  end

  task automatic expect_now(input string name, input logic [3:0] f, input logic [3:0] p, input logic b);
    exp_t e;
    e.name = name; e.flag = f; e.pix = p; e.busy = b;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic chk_px(input string name, input logic [9:0] x, input logic [3:0] f,
                        input logic [3:0] p, input logic b);
    bus.pix_x_i = x;
    expect_now(name, f, p, b);
  endtask

  // One frame: outputs must be old while frame_start is high, new one cycle later
  task automatic frame(input string name, input logic bn, input logic bp, input logic [3:0] nf);
    bus.btn_next_i    = bn;
    bus.btn_prev_i    = bp;
    bus.frame_start_i = 1'b1;
    expect_now({name, "_pre"}, cur_flag, cur_flag, 1'b0);
    bus.frame_start_i = 1'b0;
    cur_flag = nf;
    expect_now({name, "_post"}, cur_flag, cur_flag, 1'b0);
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_start_i = 1'b1;
      @(posedge clk); #1;
      bus.frame_start_i = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected run to complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b1;
    bus.frame_start_i = 1'b0;
    bus.btn_next_i    = 1'b0;
    bus.btn_prev_i    = 1'b0;
    bus.auto_en_i     = 1'b0;
    bus.pix_x_i       = 10'd321;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    expect_now("reset", 4'd0, 4'd0, 1'b0);

`ifndef FLAG_SCHEDULER_WIPE_EN
    // Auto-advance with dwell of 4 frames
    bus.auto_en_i = 1'b1;
    for (int i = 1; i <= 8; i++)
      frame("auto", 1'b0, 1'b0, (i < 4) ? 4'd0 : (i < 8) ? 4'd1 : 4'd2);
    bus.auto_en_i = 1'b0;

    // Prev presses 2 -> 1 -> 0 -> 15 (wrap)
    frame("prv_a", 1'b0, 1'b1, 4'd2); frame("prv_a", 1'b0, 1'b1, 4'd2);
    frame("prv_a", 1'b0, 1'b1, 4'd1); frame("rel",   1'b0, 1'b0, 4'd1);
    frame("prv_b", 1'b0, 1'b1, 4'd1); frame("prv_b", 1'b0, 1'b1, 4'd1);
    frame("prv_b", 1'b0, 1'b1, 4'd0); frame("rel",   1'b0, 1'b0, 4'd0);
    frame("prv_w", 1'b0, 1'b1, 4'd0); frame("prv_w", 1'b0, 1'b1, 4'd0);
    frame("prv_w", 1'b0, 1'b1, 4'd15); frame("rel",  1'b0, 1'b0, 4'd15);

    // Next wrap 15 -> 0, prev wrap 0 -> 15
    bus.pix_x_i = 10'd7;
    frame("nxt_w", 1'b1, 1'b0, 4'd15); frame("nxt_w", 1'b1, 1'b0, 4'd15);
    frame("nxt_w", 1'b1, 1'b0, 4'd0);  frame("rel",   1'b0, 1'b0, 4'd0);
    frame("prv_w2", 1'b0, 1'b1, 4'd0); frame("prv_w2", 1'b0, 1'b1, 4'd0);
    frame("prv_w2", 1'b0, 1'b1, 4'd15); frame("rel",   1'b0, 1'b0, 4'd15);

    // Long hold: one step only, then re-press steps again
    for (int i = 1; i <= 13; i++)
      frame("hold", 1'b1, 1'b0, (i < 3) ? 4'd15 : 4'd0);
    frame("rel", 1'b0, 1'b0, 4'd0);
    frame("repress", 1'b1, 1'b0, 4'd0); frame("repress", 1'b1, 1'b0, 4'd0);
    frame("repress", 1'b1, 1'b0, 4'd1); frame("rel",     1'b0, 1'b0, 4'd1);

    // Two short holds never reach the debounce threshold
    frame("short", 1'b1, 1'b0, 4'd1); frame("short", 1'b1, 1'b0, 4'd1);
    frame("short", 1'b0, 1'b0, 4'd1);
    frame("short", 1'b1, 1'b0, 4'd1); frame("short", 1'b1, 1'b0, 4'd1);
    frame("short", 1'b0, 1'b0, 4'd1);

    // Both buttons together: discarded, dwell keeps counting (step at 5th frame)
    bus.auto_en_i = 1'b1;
    frame("both", 1'b1, 1'b1, 4'd1); frame("both", 1'b1, 1'b1, 4'd1);
    frame("both", 1'b1, 1'b1, 4'd1); frame("both_rel", 1'b0, 1'b0, 4'd1);
    frame("both_dw", 1'b0, 1'b0, 4'd2);

    // Manual press on the dwell-expiry frame: single step, dwell restarts
    frame("exp_idle", 1'b0, 1'b0, 4'd2);
    frame("exp_hold", 1'b1, 1'b0, 4'd2); frame("exp_hold", 1'b1, 1'b0, 4'd2);
    frame("exp_fire", 1'b1, 1'b0, 4'd3);
    frame("exp_dw", 1'b0, 1'b0, 4'd3); frame("exp_dw", 1'b0, 1'b0, 4'd3);
    frame("exp_dw", 1'b0, 1'b0, 4'd3); frame("exp_auto", 1'b0, 1'b0, 4'd4);
`else
    // Arm buttons, then two wipes to reach flag 2
    pulse(1);
    bus.btn_next_i = 1'b1;
    pulse(3);
    chk_px("wipe1_start", 10'd0, 4'd0, 4'd0, 1'b1);
    bus.btn_next_i = 1'b0;
    pulse(40);
    chk_px("wipe1_done", 10'd0, 4'd1, 4'd1, 1'b0);
    bus.btn_next_i = 1'b1;
    pulse(3);
    bus.btn_next_i = 1'b0;
    pulse(40);
    chk_px("wipe2_done", 10'd100, 4'd2, 4'd2, 1'b0);

    // Wipe 2 -> 3: first frame shows old flag everywhere
    bus.btn_next_i = 1'b1;
    pulse(3);
    bus.btn_next_i = 1'b0;
    chk_px("w_first_0",   10'd0,   4'd2, 4'd2, 1'b1);
    chk_px("w_first_320", 10'd320, 4'd2, 4'd2, 1'b1);
    chk_px("w_first_639", 10'd639, 4'd2, 4'd2, 1'b1);
    // Prev press lands during the wipe and must be dropped
    bus.btn_prev_i = 1'b1;
    pulse(4);
    bus.btn_prev_i = 1'b0;
    pulse(6);
    chk_px("w160_0",   10'd0,   4'd2, 4'd3, 1'b1);
    chk_px("w160_159", 10'd159, 4'd2, 4'd3, 1'b1);
    chk_px("w160_160", 10'd160, 4'd2, 4'd2, 1'b1);
    pulse(29);
    chk_px("w624_623", 10'd623, 4'd2, 4'd3, 1'b1);
    chk_px("w624_624", 10'd624, 4'd2, 4'd2, 1'b1);
    pulse(1);
    chk_px("w_done_0",   10'd0,   4'd3, 4'd3, 1'b0);
    chk_px("w_done_639", 10'd639, 4'd3, 4'd3, 1'b0);
    pulse(2);
    chk_px("w_prev_ign", 10'd5, 4'd3, 4'd3, 1'b0);

    // Reset mid-wipe at wipe_x=320
    bus.btn_next_i = 1'b1;
    pulse(3);
    bus.btn_next_i = 1'b0;
    pulse(20);
    chk_px("w320_319", 10'd319, 4'd3, 4'd4, 1'b1);
    chk_px("w320_320", 10'd320, 4'd3, 4'd3, 1'b1);
    bus.pix_x_i = 10'd0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_px("rst_mid_0",   10'd0,   4'd0, 4'd0, 1'b0);
    chk_px("rst_mid_319", 10'd319, 4'd0, 4'd0, 1'b0);
    chk_px("rst_mid_639", 10'd639, 4'd0, 4'd0, 1'b0);
    pulse(1);
    chk_px("rst_mid_idle", 10'd50, 4'd0, 4'd0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
